matmul_tile_sequencer: RTL and testbench

//  Walks an output matrix tile by tile, launching one systolic multiply per tile through master_multip_control.

---
 rtl/matmul_tile_sequencer_if.sv | 28 ++
 rtl/matmul_tile_sequencer.sv | 155 +++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_tile_sequencer_if.sv
// Handshake bundle between the tile sequencer, the instruction decoder
// (start/counts) and master_multip_control (launch/done/fifo_ready/indices).
interface matmul_tile_sequencer_if #(
   parameter int IDX_W = 3
);
   logic             start;
   logic [IDX_W:0]   num_tile_rows;
   logic [IDX_W:0]   num_tile_cols;
   logic             multip_done;
   logic             fifo_ready;
   logic             multip_active;
   logic [IDX_W-1:0] submat_row;
   logic [IDX_W-1:0] submat_col;
   logic             busy;
   logic             sweep_done;

   // Sequencer side: consumes requests and controller status, drives launches.
   modport master (
      input  start, num_tile_rows, num_tile_cols, multip_done, fifo_ready,
      output multip_active, submat_row, submat_col, busy, sweep_done
   );

   // Environment side: decoder plus multiply controller.
   modport slave (
      output start, num_tile_rows, num_tile_cols, multip_done, fifo_ready,
      input  multip_active, submat_row, submat_col, busy, sweep_done
   );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer: walks the output matrix row-major one tile at a time,
// launching a single systolic multiply per tile and waiting for it to
// complete before stepping to the next tile. All outputs are registered.
module matmul_tile_sequencer #(
   parameter int width_height         = 16,
   parameter int max_out_width_height = 128
) (
   input logic                    clk,
   input logic                    reset,
   matmul_tile_sequencer_if.master bus
);
   localparam int IDX_W     = $clog2(max_out_width_height / width_height);
   localparam int MAX_TILES = max_out_width_height / width_height;

   localparam logic [IDX_W:0]   MAX_COUNT = (IDX_W + 1)'(MAX_TILES);
   localparam logic [IDX_W:0]   CNT_ONE   = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W - 1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W:0]   CNT_ZERO  = {(IDX_W + 1){1'b0}};

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_ACK  = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] ADVANCE   = 3'd4;
   localparam logic [2:0] FINISH    = 3'd5;

   // Requests larger than the physical output matrix are trimmed to it.
   function automatic logic [IDX_W:0] clamp_count(input logic [IDX_W:0] c);
      logic [IDX_W:0] r;
      if (c > MAX_COUNT) begin
         r = MAX_COUNT;
      end else begin
         r = c;
      end
      return r;
   endfunction

   logic [2:0]       state_r,      state_nxt_s;
   logic [IDX_W:0]   rows_r,       rows_nxt_s;
   logic [IDX_W:0]   cols_r,       cols_nxt_s;
   logic [IDX_W-1:0] row_r,        row_nxt_s;
   logic [IDX_W-1:0] col_r,        col_nxt_s;
   logic             active_r,     active_nxt_s;
   logic             busy_r,       busy_nxt_s;
   logic             sweep_done_r, sweep_done_nxt_s;
   logic             row_last_s;
   logic             col_last_s;

   // Indices are compared against count-1 in count width so they never wrap.
   assign row_last_s = ({1'b0, row_r} == (rows_r - CNT_ONE));
   assign col_last_s = ({1'b0, col_r} == (cols_r - CNT_ONE));

   // Next-state and next-output decode for the sweep FSM.
   always_comb begin
      state_nxt_s      = state_r;
      rows_nxt_s       = rows_r;
      cols_nxt_s       = cols_r;
      row_nxt_s        = row_r;
      col_nxt_s        = col_r;
      active_nxt_s     = 1'b0;
      sweep_done_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               rows_nxt_s = clamp_count(bus.num_tile_rows);
               cols_nxt_s = clamp_count(bus.num_tile_cols);
               row_nxt_s  = IDX_ZERO;
               col_nxt_s  = IDX_ZERO;
               if ((bus.num_tile_rows == CNT_ZERO) || (bus.num_tile_cols == CNT_ZERO)) begin
                  state_nxt_s = FINISH;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (bus.multip_done && bus.fifo_ready) begin
               active_nxt_s = 1'b1;
               state_nxt_s  = WAIT_ACK;
            end else begin
               state_nxt_s  = ISSUE;
            end
         end
         WAIT_ACK: begin
            // Controller drops done once it has left its hold state.
            if (!bus.multip_done) begin
               state_nxt_s = WAIT_DONE;
            end else begin
               state_nxt_s = WAIT_ACK;
            end
         end
         WAIT_DONE: begin
            if (bus.multip_done) begin
               state_nxt_s = ADVANCE;
            end else begin
               state_nxt_s = WAIT_DONE;
            end
         end
         ADVANCE: begin
            if (col_last_s) begin
               col_nxt_s = IDX_ZERO;
               if (row_last_s) begin
                  state_nxt_s = FINISH;
               end else begin
                  row_nxt_s   = row_r + IDX_ONE;
                  state_nxt_s = ISSUE;
               end
            end else begin
               col_nxt_s   = col_r + IDX_ONE;
               state_nxt_s = ISSUE;
            end
         end
         FINISH: begin
            sweep_done_nxt_s = 1'b1;
            state_nxt_s      = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // State, latched counts, tile indices and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         rows_r       <= CNT_ZERO;
         cols_r       <= CNT_ZERO;
         row_r        <= IDX_ZERO;
         col_r        <= IDX_ZERO;
         active_r     <= 1'b0;
         busy_r       <= 1'b0;
         sweep_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         rows_r       <= rows_nxt_s;
         cols_r       <= cols_nxt_s;
         row_r        <= row_nxt_s;
         col_r        <= col_nxt_s;
         active_r     <= active_nxt_s;
         busy_r       <= busy_nxt_s;
         sweep_done_r <= sweep_done_nxt_s;
      end
   end

   assign bus.multip_active = active_r;
   assign bus.submat_row    = row_r;
   assign bus.submat_col    = col_r;
   assign bus.busy          = busy_r;
   assign bus.sweep_done    = sweep_done_r;
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Testbench for matmul_tile_sequencer: a behavioural multiply controller,
// a launch monitor and a row-major reference list of expected tiles.
module tb_matmul_tile_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;

   matmul_tile_sequencer_if #(.IDX_W(3)) bus ();

   matmul_tile_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int sd_count = 0;
   int nobusy_launch = 0;
   int lat = 5;          // controller busy time in cycles; 0 = random 1..4
   int cnt = 0;
   int obs_q[$];         // observed launches, encoded row*100+col
   int exp_q[$];         // expected launches from the reference walk

   // Behavioural master_multip_control: done drops after a launch, returns later.
   always @(negedge clk) begin
      if (reset) begin
         bus.multip_done = 1'b1;
         cnt = 0;
      end else if (bus.multip_active) begin
         bus.multip_done = 1'b0;
         cnt = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      end else if (cnt > 0) begin
         cnt = cnt - 1;
         if (cnt == 0) bus.multip_done = 1'b1;
      end
   end

   // Record every launch and every sweep completion.
   always @(negedge clk) begin
      if (bus.multip_active === 1'b1) begin
         obs_q.push_back(int'(bus.submat_row) * 100 + int'(bus.submat_col));
         if (bus.busy !== 1'b1) nobusy_launch = nobusy_launch + 1;
      end
      if (bus.sweep_done === 1'b1) sd_count = sd_count + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests = tests + 1;
      assert (obs === expv) else begin
         fails = fails + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: tiles visited row-major over the clamped request.
   task automatic build_model(input int rows, input int cols);
      int re;
      int ce;
      re = (rows > 8) ? 8 : rows;
      ce = (cols > 8) ? 8 : cols;
      exp_q.delete();
      if (re != 0 && ce != 0) begin
         for (int r = 0; r < re; r++)
            for (int c = 0; c < ce; c++)
               exp_q.push_back(r * 100 + c);
      end
   endtask

   task automatic do_start(input int rows, input int cols);
      bus.num_tile_rows = 4'(rows);
      bus.num_tile_cols = 4'(cols);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic wait_sweep(input string tag, input int sd0, input int budget);
      int k;
      int bad;
      k = 0;
      while (sd_count == sd0 && k < budget) begin
         tick(1);
         k++;
      end
      check({tag, "_completed"}, (sd_count != sd0) ? 32'd1 : 32'd0, 32'd1);
      tick(2);
      check({tag, "_done_pulses"}, sd_count - sd0, 32'd1);
      check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_launches"}, obs_q.size(), exp_q.size());
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= obs_q.size() || obs_q[i] != exp_q[i]) bad++;
      check({tag, "_order_errs"}, bad, 32'd0);
   endtask

   initial begin
      int sd0;
      int rr;
      int cc;
      bus.start = 1'b0;
      bus.num_tile_rows = 4'd0;
      bus.num_tile_cols = 4'd0;
      bus.fifo_ready = 1'b1;

      // Reset state
      tick(3);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_active", {31'd0, bus.multip_active}, 32'd0);
      check("rst_row", {29'd0, bus.submat_row}, 32'd0);
      check("rst_col", {29'd0, bus.submat_col}, 32'd0);
      check("rst_done", {31'd0, bus.sweep_done}, 32'd0);
      reset = 1'b0;
      tick(2);

      // 1: 2x3 sweep, controller takes 5 cycles per tile
      lat = 5;
      build_model(2, 3);
      obs_q.delete();
      sd0 = sd_count;
      do_start(2, 3);
      wait_sweep("t1_2x3", sd0, 200);

      // 2: zero rows -> no launch, sweep_done two cycles after start
      build_model(0, 4);
      obs_q.delete();
      sd0 = sd_count;
      do_start(0, 4);
      check("t2_done_early", {31'd0, bus.sweep_done}, 32'd0);
      check("t2_busy", {31'd0, bus.busy}, 32'd1);
      tick(1);
      check("t2_done_at2", {31'd0, bus.sweep_done}, 32'd1);
      check("t2_busy_off", {31'd0, bus.busy}, 32'd0);
      wait_sweep("t2_0x4", sd0, 10);

      // 3: fifo_ready held low in ISSUE blocks the launch
      lat = 3;
      build_model(1, 1);
      obs_q.delete();
      sd0 = sd_count;
      bus.fifo_ready = 1'b0;
      do_start(1, 1);
      tick(10);
      check("t3_no_launch", obs_q.size(), 32'd0);
      check("t3_busy_wait", {31'd0, bus.busy}, 32'd1);
      bus.fifo_ready = 1'b1;
      tick(1);
      check("t3_pulse", {31'd0, bus.multip_active}, 32'd1);
      tick(1);
      check("t3_pulse_end", {31'd0, bus.multip_active}, 32'd0);
      wait_sweep("t3_1x1", sd0, 50);

      // 4: full 8x8 and a clamped 9x8 request
      lat = 1;
      for (int n = 0; n < 2; n++) begin
         build_model(8 + n, 8);
         obs_q.delete();
         sd0 = sd_count;
         do_start(8 + n, 8);
         wait_sweep((n == 0) ? "t4_8x8" : "t4_9x8", sd0, 1000);
         check("t4_last_tile", (obs_q.size() > 0) ? obs_q[$] : -1, 32'd707);
      end

      // 5: reset during WAIT_DONE of tile (1,2)
      lat = 5;
      obs_q.delete();
      sd0 = sd_count;
      do_start(2, 3);
      rr = 0;
      while (obs_q.size() < 6 && rr < 200) begin
         tick(1);
         rr++;
      end
      check("t5_reached", obs_q.size(), 32'd6);
      tick(1);
      check("t5_tile12", (obs_q.size() > 0) ? obs_q[$] : -1, 32'd102);
      reset = 1'b1;
      tick(1);
      check("t5_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_row", {29'd0, bus.submat_row}, 32'd0);
      check("t5_col", {29'd0, bus.submat_col}, 32'd0);
      check("t5_active", {31'd0, bus.multip_active}, 32'd0);
      reset = 1'b0;
      tick(20);
      check("t5_no_more", obs_q.size(), 32'd6);
      check("t5_no_done", sd_count - sd0, 32'd0);

      // 6: start pulses while busy are ignored
      lat = 0;
      build_model(2, 2);
      obs_q.delete();
      sd0 = sd_count;
      do_start(2, 2);
      tick(3);
      check("t6_busy1", {31'd0, bus.busy}, 32'd1);
      do_start(3, 3);
      tick(4);
      check("t6_busy2", {31'd0, bus.busy}, 32'd1);
      do_start(5, 1);
      wait_sweep("t6_2x2", sd0, 200);
      tick(5);
      check("t6_idle_quiet", obs_q.size(), 32'd4);

      // Random sweeps, including counts beyond the maximum
      for (int n = 0; n < 5; n++) begin
         rr = $urandom_range(0, 15);
         cc = $urandom_range(0, 15);
         lat = 0;
         bus.fifo_ready = 1'b1;
         build_model(rr, cc);
         obs_q.delete();
         sd0 = sd_count;
         do_start(rr, cc);
         wait_sweep($sformatf("rnd%0d_%0dx%0d", n, rr, cc), sd0, 1200);
      end

      check("launch_while_idle", nobusy_launch, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
